// File: rtl/prog_loader_if.sv
// Instruction-memory write port driven by the program loader.
interface prog_loader_if;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;

  modport master (output mem_we, mem_addr, mem_wdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/prog_loader.sv
// UART program loader: 8N1 receiver feeding a frame FSM (A5, LEN, ADDR, data, CHK) that writes
// instruction memory and holds the core in reset until a frame's checksum verifies.
module prog_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  prog_loader_if.master mem,
  output logic         cpu_rst,
  output logic         busy,
  output logic         load_done,
  output logic         load_err
);
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_END   = TW'(TO_CYC - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;
  typedef enum logic [2:0] {F_SYNC, F_LEN, F_ADDR, F_DATA, F_CHK} fstate_t;

  logic          rx_q1, rx_s, rx_d;
  ustate_t       ustate;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_valid, frame_err;
  logic [7:0]    rx_byte;

  fstate_t       fstate;
  logic [7:0]    count, ptr, sum;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  // rx_d trails the synchronized line by one cycle for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
      rx_d  <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ustate    <= U_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_byte   <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (ustate)
        U_IDLE: begin
          bit_cnt <= '0;
          if (rx_d && !rx_s) ustate <= U_START;
        end
        U_START: begin
          if (bit_cnt == HALF_END) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            ustate  <= rx_s ? U_IDLE : U_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (bit_cnt == BIT_END) begin
            bit_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) ustate <= U_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (bit_cnt == BIT_END) begin
            bit_cnt <= '0;
            ustate  <= U_IDLE;
            if (rx_s) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ustate <= U_IDLE;
      endcase
    end
  end

  assign timeout = (to_cnt == TO_END);

  // LEN=0 loads 256 bytes: count walks 0,FF..1, so the last byte is always seen at count==1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate        <= F_SYNC;
      count         <= '0;
      ptr           <= '0;
      sum           <= '0;
      to_cnt        <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      cpu_rst       <= 1'b0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      mem.mem_we <= 1'b0;
      load_done  <= 1'b0;
      to_cnt     <= (fstate == F_SYNC || rx_valid) ? '0 : to_cnt + 1'b1;
      if (rx_valid) begin
        case (fstate)
          F_SYNC: begin
            if (rx_byte == SYNC_BYTE) begin
              fstate  <= F_LEN;
              cpu_rst <= 1'b1;
              busy    <= 1'b1;
              sum     <= '0;
            end
          end
          F_LEN: begin
            count  <= rx_byte;
            sum    <= sum + rx_byte;
            fstate <= F_ADDR;
          end
          F_ADDR: begin
            ptr    <= rx_byte;
            sum    <= sum + rx_byte;
            fstate <= F_DATA;
          end
          F_DATA: begin
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= ptr;
            mem.mem_wdata <= rx_byte;
            ptr           <= ptr + 1'b1;
            sum           <= sum + rx_byte;
            count         <= count - 1'b1;
            if (count == 8'd1) fstate <= F_CHK;
          end
          F_CHK: begin
            if (8'(sum + rx_byte) == 8'd0) begin
              load_done <= 1'b1;
              load_err  <= 1'b0;
              cpu_rst   <= 1'b0;
            end else begin
              load_err  <= 1'b1;
            end
            busy   <= 1'b0;
            fstate <= F_SYNC;
          end
          default: fstate <= F_SYNC;
        endcase
      end else if (fstate != F_SYNC && (frame_err || timeout)) begin
        load_err <= 1'b1;
        busy     <= 1'b0;
        fstate   <= F_SYNC;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame vector table plus glitch and mid-frame reset sequences.
module tb_prog_loader;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic cpu_rst, busy, load_done, load_err;

  prog_loader_if mif ();

  prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .rst(rst), .rx(rx), .mem(mif.master),
    .cpu_rst(cpu_rst), .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write must happen with the core held in reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (mif.mem_we) begin
        wr_cnt++;
        wr_addr_q.push_back(mif.mem_addr);
        wr_data_q.push_back(mif.mem_wdata);
        check("cpu_rst_during_write", int'(cpu_rst), 1);
      end
      if (load_done) done_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic clear_log();
    wr_cnt = 0;
    done_cnt = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  typedef struct {
    logic [0:7][7:0] b;
    int              n;
    int              bad_idx;
    int              idle;
    int              n_wr;
    logic [7:0]      a_first, d_first, a_last, d_last;
    int              done;
    logic            err;
    logic            crst;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{b: {8'h00, 8'hA5, 8'h03, 8'h10, 8'h10, 8'h2A, 8'h40, 8'h73}, n: 8, bad_idx: -1, idle: 40,
                n_wr: 3, a_first: 8'h10, d_first: 8'h10, a_last: 8'h12, d_last: 8'h40, done: 1, err: 1'b0, crst: 1'b0};
    vecs[1] = '{b: {8'hA5, 8'h02, 8'hFF, 8'h11, 8'h22, 8'hCC, 8'h00, 8'h00}, n: 6, bad_idx: -1, idle: 40,
                n_wr: 2, a_first: 8'hFF, d_first: 8'h11, a_last: 8'h00, d_last: 8'h22, done: 1, err: 1'b0, crst: 1'b0};
    vecs[2] = '{b: {8'hA5, 8'h03, 8'h10, 8'h10, 8'h2A, 8'h40, 8'h74, 8'h00}, n: 7, bad_idx: -1, idle: 40,
                n_wr: 3, a_first: 8'h10, d_first: 8'h10, a_last: 8'h12, d_last: 8'h40, done: 0, err: 1'b1, crst: 1'b1};
    vecs[3] = '{b: {8'hA5, 8'h03, 8'h10, 8'h10, 8'h2A, 8'h40, 8'h73, 8'h00}, n: 7, bad_idx: -1, idle: 40,
                n_wr: 3, a_first: 8'h10, d_first: 8'h10, a_last: 8'h12, d_last: 8'h40, done: 1, err: 1'b0, crst: 1'b0};
    vecs[4] = '{b: {8'hA5, 8'h03, 8'h10, 8'h10, 8'h2A, 8'h00, 8'h00, 8'h00}, n: 5, bad_idx: 4, idle: 40,
                n_wr: 1, a_first: 8'h10, d_first: 8'h10, a_last: 8'h10, d_last: 8'h10, done: 0, err: 1'b1, crst: 1'b1};
    vecs[5] = '{b: {8'hA5, 8'h03, 8'h10, 8'h10, 8'h2A, 8'h40, 8'h73, 8'h00}, n: 7, bad_idx: -1, idle: 40,
                n_wr: 3, a_first: 8'h10, d_first: 8'h10, a_last: 8'h12, d_last: 8'h40, done: 1, err: 1'b0, crst: 1'b0};
    vecs[6] = '{b: {8'hA5, 8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3, bad_idx: -1, idle: 220,
                n_wr: 0, a_first: 8'h00, d_first: 8'h00, a_last: 8'h00, d_last: 8'h00, done: 0, err: 1'b1, crst: 1'b1};

    repeat (3) @(negedge clk);
    check("rst_mem_we", int'(mif.mem_we), 0);
    check("rst_cpu_rst", int'(cpu_rst), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_mem_addr", int'(mif.mem_addr), 0);
    check("idle_mem_wdata", int'(mif.mem_wdata), 0);
    check("idle_load_done", int'(load_done), 0);
    check("idle_load_err", int'(load_err), 0);

    for (int v = 0; v < 7; v++) begin
      clear_log();
      for (int k = 0; k < vecs[v].n; k++)
        send_byte(vecs[v].b[k], (k == vecs[v].bad_idx) ? 1'b0 : 1'b1);
      repeat (vecs[v].idle) @(negedge clk);
      check($sformatf("v%0d_writes", v), wr_cnt, vecs[v].n_wr);
      if (wr_cnt > 0 && vecs[v].n_wr > 0) begin
        check($sformatf("v%0d_first_addr", v), int'(wr_addr_q[0]), int'(vecs[v].a_first));
        check($sformatf("v%0d_first_data", v), int'(wr_data_q[0]), int'(vecs[v].d_first));
        check($sformatf("v%0d_last_addr", v), int'(wr_addr_q[wr_cnt-1]), int'(vecs[v].a_last));
        check($sformatf("v%0d_last_data", v), int'(wr_data_q[wr_cnt-1]), int'(vecs[v].d_last));
      end
      check($sformatf("v%0d_done_pulses", v), done_cnt, vecs[v].done);
      check($sformatf("v%0d_load_err", v), int'(load_err), int'(vecs[v].err));
      check($sformatf("v%0d_cpu_rst", v), int'(cpu_rst), int'(vecs[v].crst));
      check($sformatf("v%0d_busy", v), int'(busy), 0);
    end

    // A 3-cycle glitch inside a frame must not be taken as a data byte.
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h20, 1'b1);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy", int'(busy), 1);
    check("glitch_no_write", wr_cnt, 0);
    send_byte(8'h55, 1'b1);
    send_byte(8'h8A, 1'b1);
    repeat (40) @(negedge clk);
    check("glitch_writes", wr_cnt, 1);
    if (wr_cnt > 0) begin
      check("glitch_addr", int'(wr_addr_q[0]), 8'h20);
      check("glitch_data", int'(wr_data_q[0]), 8'h55);
    end
    check("glitch_done", done_cnt, 1);
    check("glitch_err", int'(load_err), 0);

    // Reset in the middle of a data byte.
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h3C, 1'b1);
    rx = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    check("mid_writes", wr_cnt, 1);
    check("mid_addr", int'(mif.mem_addr), 8'h30);
    check("mid_cpu_rst", int'(cpu_rst), 1);
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_mem_we", int'(mif.mem_we), 0);
    check("arst_mem_addr", int'(mif.mem_addr), 0);
    check("arst_mem_wdata", int'(mif.mem_wdata), 0);
    check("arst_cpu_rst", int'(cpu_rst), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_load_done", int'(load_done), 0);
    check("arst_load_err", int'(load_err), 0);
    rst = 1'b0;
    rx = 1'b1;
    repeat (120) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_cpu_rst", int'(cpu_rst), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
